// File: rtl/decoder_stage.sv
// Instruction decode stage: turns a 32-bit RV32I word into a registered ALU/memory
// control bundle, stalls across memory accesses and raises traps for illegal/system/timeout cases.
module decoder_stage #(
  parameter int MEM_TIMEOUT   = 15,
  parameter int ENABLE_SYSTEM = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             mem_done,
  input  logic             trap_ack,
  output logic             out_valid,
  output logic [1:0]       srcA,
  output logic [2:0]       srcB,
  output logic [4:0]       aop,
  output logic [4:0]       memi,
  output logic             ws,
  output logic             mwe,
  output logic             rfwe,
  output logic             jal,
  output logic             jalr,
  output logic             b,
  output logic             enpc,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TRAP     = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd3;

  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_SYSTEM = 7'd115;

  typedef struct packed {
    logic [1:0] src_a;
    logic [2:0] src_b;
    logic [4:0] aop;
    logic [4:0] memi;
    logic       ws;
    logic       mwe;
    logic       rfwe;
    logic       jal;
    logic       jalr;
    logic       b;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       tmo_q, tmo_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             out_valid_q, out_valid_d;
  logic             enpc_q, enpc_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      dec_ctrl;
  logic       dec_illegal;
  logic       dec_mem;
  logic       dec_sys;
  logic       accept;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign f3          = instr[14:12];
  assign f7          = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  assign in_ready = (state_q == ST_RUN) && !rst;
  assign accept   = in_valid && in_ready;

  // Combinational decode of the presented word
  always_comb begin
    dec_ctrl    = CTRL_NONE;
    dec_illegal = 1'b0;
    dec_mem     = 1'b0;
    dec_sys     = 1'b0;
    if (instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (opcode)
        OP_REG: begin
          dec_ctrl.aop  = {f7[6:5], f3};
          dec_ctrl.rfwe = 1'b1;
          if (!((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)))))
            dec_illegal = 1'b1;
        end
        OP_IMM: begin
          dec_ctrl.src_b = 3'd1;
          dec_ctrl.aop   = (f3 == 3'b101) ? {1'b0, f7[5], 3'b101} : {2'b00, f3};
          dec_ctrl.rfwe  = 1'b1;
          if ((f3 == 3'b001) && (f7 != 7'h00))
            dec_illegal = 1'b1;
          if ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20))
            dec_illegal = 1'b1;
        end
        OP_LOAD: begin
          dec_ctrl.src_b = 3'd1;
          dec_ctrl.memi  = {2'b10, f3};
          dec_ctrl.ws    = 1'b1;
          dec_ctrl.rfwe  = 1'b1;
          dec_mem        = 1'b1;
          if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111))
            dec_illegal = 1'b1;
        end
        OP_STORE: begin
          dec_ctrl.src_a = 2'd3;
          dec_ctrl.src_b = 3'd3;
          dec_ctrl.memi  = {2'b01, f3};
          dec_ctrl.mwe   = 1'b1;
          dec_mem        = 1'b1;
          if (f3 > 3'b010)
            dec_illegal = 1'b1;
        end
        OP_BRANCH: begin
          dec_ctrl.aop = {2'b11, f3};
          dec_ctrl.b   = 1'b1;
          if ((f3 == 3'b010) || (f3 == 3'b011))
            dec_illegal = 1'b1;
        end
        OP_JALR: begin
          dec_ctrl.src_a = 2'd1;
          dec_ctrl.src_b = 3'd4;
          dec_ctrl.rfwe  = 1'b1;
          dec_ctrl.jalr  = 1'b1;
          if (f3 != 3'b000)
            dec_illegal = 1'b1;
        end
        OP_JAL: begin
          dec_ctrl.src_a = 2'd1;
          dec_ctrl.src_b = 3'd4;
          dec_ctrl.rfwe  = 1'b1;
          dec_ctrl.jal   = 1'b1;
        end
        OP_LUI: begin
          dec_ctrl.src_a = 2'd2;
          dec_ctrl.src_b = 3'd2;
          dec_ctrl.rfwe  = 1'b1;
        end
        OP_AUIPC: begin
          dec_ctrl.src_a = 2'd1;
          dec_ctrl.src_b = 3'd2;
          dec_ctrl.rfwe  = 1'b1;
        end
        OP_SYSTEM: begin
          if (ENABLE_SYSTEM != 0) dec_sys = 1'b1;
          else                    dec_illegal = 1'b1;
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Next-state: controls are held only while a memory access is outstanding
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    ctrl_d      = ctrl_q;
    out_valid_d = 1'b0;
    enpc_d      = 1'b0;
    trap_d      = trap_q;
    cause_d     = cause_q;
    ill_cnt_d   = ill_cnt_q;
    case (state_q)
      ST_RUN: begin
        ctrl_d = CTRL_NONE;
        if (accept) begin
          if (dec_illegal) begin
            trap_d    = 1'b1;
            cause_d   = CAUSE_ILLEGAL;
            ill_cnt_d = sat_inc(ill_cnt_q);
            state_d   = ST_TRAP;
          end else if (dec_sys) begin
            trap_d  = 1'b1;
            cause_d = CAUSE_SYSTEM;
            state_d = ST_TRAP;
          end else begin
            out_valid_d = 1'b1;
            ctrl_d      = dec_ctrl;
            if (dec_mem) begin
              tmo_d   = 8'd0;
              state_d = ST_MEM_WAIT;
            end else begin
              enpc_d = 1'b1;
            end
          end
        end
      end
      ST_MEM_WAIT: begin
        tmo_d = tmo_q + 8'd1;
        if (mem_done) begin
          enpc_d  = 1'b1;
          ctrl_d  = CTRL_NONE;
          state_d = ST_RUN;
        end else if ((tmo_q + 8'd1) == TMO_LIMIT) begin
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          ctrl_d  = CTRL_NONE;
          state_d = ST_TRAP;
        end
      end
      ST_TRAP: begin
        ctrl_d = CTRL_NONE;
        if (trap_ack) begin
          trap_d  = 1'b0;
          cause_d = CAUSE_NONE;
          state_d = ST_RUN;
        end
      end
      default: begin
        ctrl_d  = CTRL_NONE;
        trap_d  = 1'b0;
        cause_d = CAUSE_NONE;
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      tmo_q       <= 8'd0;
      ctrl_q      <= CTRL_NONE;
      out_valid_q <= 1'b0;
      enpc_q      <= 1'b0;
      trap_q      <= 1'b0;
      cause_q     <= CAUSE_NONE;
      ill_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      enpc_q      <= enpc_d;
      trap_q      <= trap_d;
      cause_q     <= cause_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign srcA        = ctrl_q.src_a;
  assign srcB        = ctrl_q.src_b;
  assign aop         = ctrl_q.aop;
  assign memi        = ctrl_q.memi;
  assign ws          = ctrl_q.ws;
  assign mwe         = ctrl_q.mwe;
  assign rfwe        = ctrl_q.rfwe;
  assign jal         = ctrl_q.jal;
  assign jalr        = ctrl_q.jalr;
  assign b           = ctrl_q.b;
  assign enpc        = enpc_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_decoder_stage.sv
// Bench for decoder_stage: a cycle-level reference model checked every cycle, plus
// directed vectors with literal expectations. A second instance has system calls disabled.
module tb_decoder_stage;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst, in_valid, mem_done, trap_ack;
  logic [31:0] instr;

  logic in_ready, out_valid, ws, mwe, rfwe, jal, jalr, b, enpc, trap;
  logic [1:0] srcA, trap_cause;
  logic [2:0] srcB;
  logic [4:0] aop, memi;
  logic [7:0] illegal_cnt;

  logic z_in_ready, z_out_valid, z_ws, z_mwe, z_rfwe, z_jal, z_jalr, z_b, z_enpc, z_trap;
  logic [1:0] z_srcA, z_trap_cause;
  logic [2:0] z_srcB;
  logic [4:0] z_aop, z_memi;
  logic [7:0] z_illegal_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_stage #(.MEM_TIMEOUT(TMO), .ENABLE_SYSTEM(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .mem_done(mem_done), .trap_ack(trap_ack), .out_valid(out_valid), .srcA(srcA),
    .srcB(srcB), .aop(aop), .memi(memi), .ws(ws), .mwe(mwe), .rfwe(rfwe), .jal(jal),
    .jalr(jalr), .b(b), .enpc(enpc), .trap(trap), .trap_cause(trap_cause),
    .illegal_cnt(illegal_cnt));

  decoder_stage #(.MEM_TIMEOUT(TMO), .ENABLE_SYSTEM(0), .CNT_W(8)) dut_nosys (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready), .instr(instr),
    .mem_done(mem_done), .trap_ack(trap_ack), .out_valid(z_out_valid), .srcA(z_srcA),
    .srcB(z_srcB), .aop(z_aop), .memi(z_memi), .ws(z_ws), .mwe(z_mwe), .rfwe(z_rfwe),
    .jal(z_jal), .jalr(z_jalr), .b(z_b), .enpc(z_enpc), .trap(z_trap),
    .trap_cause(z_trap_cause), .illegal_cnt(z_illegal_cnt));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bundle = {srcA,srcB,aop,memi,ws,mwe,rfwe,jal,jalr,b}
  function automatic logic [20:0] mdl_ctrl(input logic [31:0] x);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] ia;
    f3 = x[14:12];
    f7 = x[31:25];
    ia = (f3 == 3'b101) ? {1'b0, f7[5], 3'b101} : {2'b00, f3};
    case (x[6:0])
      7'd51:   return {2'd0, 3'd0, f7[6:5], f3, 5'd0, 6'b001000};
      7'd19:   return {2'd0, 3'd1, ia, 5'd0, 6'b001000};
      7'd3:    return {2'd0, 3'd1, 5'd0, 2'b10, f3, 6'b101000};
      7'd35:   return {2'd3, 3'd3, 5'd0, 2'b01, f3, 6'b010000};
      7'd99:   return {2'd0, 3'd0, 2'b11, f3, 5'd0, 6'b000001};
      7'd103:  return {2'd1, 3'd4, 5'd0, 5'd0, 6'b001010};
      7'd111:  return {2'd1, 3'd4, 5'd0, 5'd0, 6'b001100};
      7'd55:   return {2'd2, 3'd2, 5'd0, 5'd0, 6'b001000};
      7'd23:   return {2'd1, 3'd2, 5'd0, 5'd0, 6'b001000};
      default: return 21'd0;
    endcase
  endfunction

  // 0 plain, 1 memory, 2 illegal, 3 system
  function automatic int mdl_kind(input logic [31:0] x, input bit sys_en);
    int op, f3, f7;
    op = int'(x[6:0]);
    f3 = int'(x[14:12]);
    f7 = int'(x[31:25]);
    if (x[1:0] != 2'b11) return 2;
    if (op == 51) return (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) ? 0 : 2;
    if (op == 19) begin
      if (f3 == 1 && f7 != 0) return 2;
      if (f3 == 5 && f7 != 0 && f7 != 32) return 2;
      return 0;
    end
    if (op == 3)   return (f3 == 3 || f3 >= 6) ? 2 : 1;
    if (op == 35)  return (f3 > 2) ? 2 : 1;
    if (op == 99)  return (f3 == 2 || f3 == 3) ? 2 : 0;
    if (op == 103) return (f3 != 0) ? 2 : 0;
    if (op == 111 || op == 55 || op == 23) return 0;
    if (op == 115) return sys_en ? 3 : 2;
    return 2;
  endfunction

  bit m_run = 1, m_mem = 0, m_trap = 0;
  int m_wait = 0;
  bit e_valid = 0, e_enpc = 0, e_trap = 0;
  logic [20:0] e_ctrl = '0;
  logic [1:0] e_cause = '0;
  int e_cnt = 0;

  always @(posedge clk) begin
    int k;
    if (rst) begin
      m_run = 1; m_mem = 0; m_trap = 0; m_wait = 0;
      e_valid = 0; e_enpc = 0; e_trap = 0; e_ctrl = '0; e_cause = 0; e_cnt = 0;
    end else if (m_run) begin
      e_valid = 0; e_enpc = 0; e_ctrl = '0;
      if (in_valid) begin
        k = mdl_kind(instr, 1'b1);
        if (k == 2) begin
          e_trap = 1; e_cause = 1; e_cnt = (e_cnt < 255) ? e_cnt + 1 : 255;
          m_run = 0; m_trap = 1;
        end else if (k == 3) begin
          e_trap = 1; e_cause = 3; m_run = 0; m_trap = 1;
        end else begin
          e_valid = 1; e_ctrl = mdl_ctrl(instr);
          if (k == 1) begin m_run = 0; m_mem = 1; m_wait = 0; end
          else e_enpc = 1;
        end
      end
    end else if (m_mem) begin
      e_valid = 0; e_enpc = 0;
      m_wait++;
      if (mem_done) begin
        e_enpc = 1; e_ctrl = '0; m_mem = 0; m_run = 1;
      end else if (m_wait == TMO) begin
        e_trap = 1; e_cause = 2; e_ctrl = '0; m_mem = 0; m_trap = 1;
      end
    end else begin
      e_valid = 0; e_enpc = 0;
      if (trap_ack) begin
        e_trap = 0; e_cause = 0; m_trap = 0; m_run = 1;
      end
    end
  end

  always @(negedge clk) begin
    if ($time > 8) begin
      check("bundle",
            {30'd0, out_valid, srcA, srcB, aop, memi, ws, mwe, rfwe, jal, jalr, b,
             enpc, trap, trap_cause, illegal_cnt},
            {30'd0, e_valid, e_ctrl, e_enpc, e_trap, e_cause, e_cnt[7:0]});
      check("in_ready", {63'd0, in_ready}, {63'd0, (m_run && !rst)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x);
    in_valid = 1'b1;
    instr    = x;
    tick();
    in_valid = 1'b0;
    instr    = 32'd0;
  endtask

  // Issue one word, then complete memory accesses / acknowledge traps until ready again
  task automatic run_instr(input logic [31:0] x);
    send(x);
    for (int g = 0; g < 40 && !in_ready; g++) begin
      if (trap) trap_ack = 1'b1;
      else      mem_done = 1'b1;
      tick();
      trap_ack = 1'b0;
      mem_done = 1'b0;
    end
    check("settle_ready", {63'd0, in_ready}, 64'd1);
  endtask

  logic [31:0] vecs [20] = '{
    32'h40208133, 32'h0020D133, 32'h4020D133, 32'h00208463, 32'h008000EF,
    32'h000080E7, 32'h000012B7, 32'h00001297, 32'h00108093, 32'h00109093,
    32'h00208023, 32'h0000C183, 32'h40209133, 32'h40109093, 32'h0000B183,
    32'h0020B023, 32'h0020A463, 32'h000090E7, 32'h00208130, 32'h0000007F};

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; mem_done = 1'b0; trap_ack = 1'b0;
    tick(); tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_cnt", {56'd0, illegal_cnt}, 64'd0);
    check("rst_ready_low", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {63'd0, in_ready}, 64'd1);

    // add x3,x1,x2
    send(32'h002081B3);
    check("add_valid", {63'd0, out_valid}, 64'd1);
    check("add_ctrl", {51'd0, aop, srcA, srcB, rfwe, enpc}, {51'd0, 5'd0, 2'd0, 3'd0, 1'b1, 1'b1});
    tick();
    check("enpc_pulse", {63'd0, enpc}, 64'd0);

    // lw with mem_done three cycles after accept
    send(32'h0000A183);
    check("lw_ws_memi", {58'd0, ws, memi}, {58'd0, 1'b1, 5'b10010});
    check("lw_ready_low", {63'd0, in_ready}, 64'd0);
    tick(); tick();
    check("lw_held_memi", {59'd0, memi}, {59'd0, 5'b10010});
    mem_done = 1'b1; tick(); mem_done = 1'b0;
    check("lw_enpc", {62'd0, enpc, in_ready}, {62'd0, 2'b11});

    // sw with no completion -> timeout trap
    send(32'h0020A023);
    k = 0;
    while (!trap && k < 40) begin tick(); k++; end
    check("sw_timeout_cycles", 64'(k), 64'd15);
    check("sw_cause", {62'd0, trap_cause}, 64'd2);
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    check("sw_ack", {61'd0, trap, trap_cause}, 64'd0);
    check("sw_ack_ready", {63'd0, in_ready}, 64'd1);

    // stray acknowledge / completion in RUN are ignored
    trap_ack = 1'b1; mem_done = 1'b1; tick(); trap_ack = 1'b0; mem_done = 1'b0;
    tick();

    // srai
    send(32'h4020D193);
    check("srai_aop", {59'd0, aop}, {59'd0, 5'b01101});
    tick();

    for (int i = 0; i < 20; i++) run_instr(vecs[i]);
    // back-to-back legal accepts
    in_valid = 1'b1; instr = 32'h00108093; tick(); instr = 32'h002081B3; tick();
    in_valid = 1'b0; tick();

    // reset in the middle of a memory wait
    send(32'h0000A183);
    tick(); tick();
    rst = 1'b1; tick();
    check("mid_rst_outs", {45'd0, out_valid, memi, ws, rfwe, enpc, trap, trap_cause, illegal_cnt}, 64'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {63'd0, in_ready}, 64'd1);

    // ecall with system enabled vs disabled
    send(32'h00000073);
    check("ecall_cause", {62'd0, trap_cause}, 64'd3);
    check("ecall_cnt", {56'd0, illegal_cnt}, 64'd0);
    check("ecall_nosys_cause", {62'd0, z_trap_cause}, 64'd1);
    check("ecall_nosys_cnt", {56'd0, z_illegal_cnt}, 64'd1);
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;

    // saturating illegal count
    for (int i = 0; i < 260; i++) begin
      send(32'hFFFFFFFF);
      if (i == 0 || i == 259) check("ill_cause", {62'd0, trap_cause}, 64'd1);
      trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    end
    check("ill_sat", {56'd0, illegal_cnt}, 64'd255);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
